// File: rtl/picorv32_avl_master.sv
// rtl/picorv32_avl_master.sv - picorv32 native memory port to Avalon-MM master bridge
// Single-beat Avalon commands with calibration gating, access timeout and stale-beat discard.
module picorv32_avl_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
  parameter int unsigned STALE_W        = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [20:0] avl_address,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  output logic        avl_read,
  output logic        avl_write,
  output logic [2:0]  avl_burstcount,
  output logic        avl_beginbursttransfer,
  input  logic        avl_waitrequest_n,
  input  logic        avl_readdatavalid,
  input  logic [31:0] avl_readdata,
  input  logic        local_init_done,
  input  logic        local_cal_fail,
  output logic        err_timeout,
  output logic        err_calfail
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RDWAIT = 2'd2, DONE = 2'd3} state_t;

  state_t             state, state_next;
  logic [TW-1:0]      tcnt;
  logic [STALE_W-1:0] stale, stale_next;
  logic               is_write;

  logic issue, calfail_hit, timeout_hit, beat_take;
  logic timed_out, stale_full, stale_beat, req_write, stale_inc;

  logic        mem_ready_d, avl_read_d, avl_write_d, begin_d;
  logic        err_timeout_d, err_calfail_d;
  logic [31:0] mem_rdata_d, writedata_d;
  logic [20:0] address_d;
  logic [3:0]  byteenable_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:23], mem_addr[1:0]};

  assign timed_out      = (tcnt == T_LAST);
  assign stale_full     = &stale;
  assign stale_beat     = avl_readdatavalid && (stale != '0);
  assign req_write      = (mem_wstrb != 4'h0);
  assign avl_burstcount = 3'd1;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state                  <= IDLE;
      tcnt                   <= '0;
      stale                  <= '0;
      is_write               <= 1'b0;
      mem_ready              <= 1'b0;
      mem_rdata              <= '0;
      avl_address            <= '0;
      avl_writedata          <= '0;
      avl_byteenable         <= 4'h0;
      avl_read               <= 1'b0;
      avl_write              <= 1'b0;
      avl_beginbursttransfer <= 1'b0;
      err_timeout            <= 1'b0;
      err_calfail            <= 1'b0;
    end else begin
      state <= state_next;
      if (issue)
        tcnt <= '0;
      else if (state == CMD || state == RDWAIT)
        tcnt <= tcnt + TW'(1);
      stale <= stale_next;
      if (issue)
        is_write <= req_write;
      mem_ready              <= mem_ready_d;
      mem_rdata              <= mem_rdata_d;
      avl_address            <= address_d;
      avl_writedata          <= writedata_d;
      avl_byteenable         <= byteenable_d;
      avl_read               <= avl_read_d;
      avl_write              <= avl_write_d;
      avl_beginbursttransfer <= begin_d;
      err_timeout            <= err_timeout_d;
      err_calfail            <= err_calfail_d;
    end
  end

  always_comb begin
    state_next  = state;
    issue       = 1'b0;
    calfail_hit = 1'b0;
    timeout_hit = 1'b0;
    beat_take   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid && !mem_ready) begin
          if (local_cal_fail) begin
            state_next  = DONE;
            calfail_hit = 1'b1;
          end else if (local_init_done && !stale_full) begin
            state_next = CMD;
            issue      = 1'b1;
          end
        end
      end
      CMD: begin
        if (avl_waitrequest_n)
          state_next = is_write ? DONE : RDWAIT;
        else if (timed_out) begin
          state_next  = DONE;
          timeout_hit = 1'b1;
        end
      end
      RDWAIT: begin
        if (avl_readdatavalid && stale == '0) begin
          state_next = DONE;
          beat_take  = 1'b1;
        end else if (timed_out) begin
          state_next  = DONE;
          timeout_hit = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // An abandoned read leaves one beat in flight; beats owed to it are dropped in any state.
    stale_inc  = timeout_hit && (state == RDWAIT);
    stale_next = stale;
    if (stale_inc && !stale_beat && !stale_full)
      stale_next = stale + STALE_W'(1);
    else if (stale_beat && !stale_inc)
      stale_next = stale - STALE_W'(1);
  end

  always_comb begin
    mem_ready_d   = (state_next == DONE);
    mem_rdata_d   = mem_rdata;
    if (beat_take)
      mem_rdata_d = avl_readdata;
    else if (calfail_hit || timeout_hit)
      mem_rdata_d = ERR_DATA;
    avl_read_d    = (state_next == CMD) && (issue ? !req_write : !is_write);
    avl_write_d   = (state_next == CMD) && (issue ? req_write : is_write);
    begin_d       = issue;
    address_d     = issue ? mem_addr[22:2] : avl_address;
    writedata_d   = issue ? mem_wdata : avl_writedata;
    byteenable_d  = avl_byteenable;
    if (issue)
      byteenable_d = req_write ? mem_wstrb : 4'hF;
    err_timeout_d = err_timeout || timeout_hit;
    err_calfail_d = err_calfail || calfail_hit;
  end

endmodule

// File: tb/tb_picorv32_avl_master.sv
// tb/tb_picorv32_avl_master.sv - scoreboard bench for picorv32_avl_master
// dut0 (timeout 16) covers commands, gating, cal-fail and reset; dut1 (timeout 8) covers timeout/stale.
module tb_picorv32_avl_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        reset_reset;
  logic        mem_valid, mem_ready, avl_read, avl_write, avl_beginbursttransfer;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, avl_writedata, avl_readdata;
  logic [3:0]  mem_wstrb, avl_byteenable;
  logic [20:0] avl_address;
  logic [2:0]  avl_burstcount;
  logic        avl_waitrequest_n, avl_readdatavalid, local_init_done, local_cal_fail;
  logic        err_timeout, err_calfail;

  logic        t_mem_valid, t_mem_ready, t_avl_read, t_avl_write, t_avl_begin;
  logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata, t_avl_writedata, t_avl_readdata;
  logic [3:0]  t_mem_wstrb, t_avl_byteenable;
  logic [20:0] t_avl_address;
  logic [2:0]  t_avl_burstcount;
  logic        t_avl_waitrequest_n, t_avl_readdatavalid, t_local_init_done, t_local_cal_fail;
  logic        t_err_timeout, t_err_calfail;

  picorv32_avl_master #(.TIMEOUT_CYCLES(16)) dut0 (
    .clk_clk(clk), .reset_reset(reset_reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .avl_address(avl_address), .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
    .avl_read(avl_read), .avl_write(avl_write), .avl_burstcount(avl_burstcount),
    .avl_beginbursttransfer(avl_beginbursttransfer), .avl_waitrequest_n(avl_waitrequest_n),
    .avl_readdatavalid(avl_readdatavalid), .avl_readdata(avl_readdata),
    .local_init_done(local_init_done), .local_cal_fail(local_cal_fail),
    .err_timeout(err_timeout), .err_calfail(err_calfail)
  );

  picorv32_avl_master #(.TIMEOUT_CYCLES(8)) dut1 (
    .clk_clk(clk), .reset_reset(reset_reset),
    .mem_valid(t_mem_valid), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_wstrb(t_mem_wstrb),
    .mem_ready(t_mem_ready), .mem_rdata(t_mem_rdata),
    .avl_address(t_avl_address), .avl_writedata(t_avl_writedata), .avl_byteenable(t_avl_byteenable),
    .avl_read(t_avl_read), .avl_write(t_avl_write), .avl_burstcount(t_avl_burstcount),
    .avl_beginbursttransfer(t_avl_begin), .avl_waitrequest_n(t_avl_waitrequest_n),
    .avl_readdatavalid(t_avl_readdatavalid), .avl_readdata(t_avl_readdata),
    .local_init_done(t_local_init_done), .local_cal_fail(t_local_cal_fail),
    .err_timeout(t_err_timeout), .err_calfail(t_err_calfail)
  );

  typedef struct { int cyc; logic chk; logic [31:0] data; } rdy_t;
  typedef struct { int start; int acc; logic wr; logic [20:0] addr; logic [3:0] be; logic [31:0] data; } cmd_t;

  rdy_t exp_q[$];
  rdy_t t_exp_q[$];
  cmd_t cmd_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_ready(input int id, input logic [31:0] rd);
    rdy_t e;
    if ((id == 0 && exp_q.size() == 0) || (id == 1 && t_exp_q.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_ready dut%0d rdata=%h cycle=%0d", id, rd, cyc);
    end else begin
      if (id == 0) e = exp_q.pop_front();
      else         e = t_exp_q.pop_front();
      chk(id == 0 ? "ready_cycle" : "t_ready_cycle", cyc, e.cyc);
      if (e.chk) chk(id == 0 ? "ready_rdata" : "t_ready_rdata", rd, e.data);
    end
  endtask

  // Ready scoreboard
  always @(negedge clk) begin
    if (mem_ready)   check_ready(0, mem_rdata);
    if (t_mem_ready) check_ready(1, t_mem_rdata);
  end

  // Command scoreboard for dut0: fields checked every command cycle, timing at start/accept
  logic prev_cmd = 1'b0;
  always @(negedge clk) begin
    cmd_t ce;
    if (avl_read || avl_write) begin
      if (cmd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd rd=%b wr=%b addr=%h cycle=%0d", avl_read, avl_write, avl_address, cyc);
      end else begin
        ce = cmd_q[0];
        if (!prev_cmd) begin
          chk("cmd_start_cycle", cyc, ce.start);
          chk("begin_first", avl_beginbursttransfer, 1);
        end else begin
          chk("begin_later", avl_beginbursttransfer, 0);
        end
        chk("cmd_write", avl_write, ce.wr);
        chk("cmd_read", avl_read, !ce.wr);
        chk("cmd_addr", avl_address, ce.addr);
        chk("cmd_be", avl_byteenable, ce.be);
        if (ce.wr) chk("cmd_wdata", avl_writedata, ce.data);
        chk("burstcount", avl_burstcount, 1);
        if (avl_waitrequest_n) begin
          chk("cmd_accept_cycle", cyc, ce.acc);
          void'(cmd_q.pop_front());
        end
      end
    end else begin
      chk("begin_idle", avl_beginbursttransfer, 0);
    end
    prev_cmd = avl_read || avl_write;
  end

  // dut0 slave: programmable waitrequest cycles and read response delay
  int          wait_left = 0;
  int          rd_delay = 0;
  logic [31:0] rd_data = '0;
  logic        beat_pend = 1'b0;
  int          beat_at = 0;
  logic [31:0] beat_data = '0;
  always @(posedge clk) begin
    #1;
    avl_readdatavalid = 1'b0;
    if (beat_pend && cyc == beat_at) begin
      avl_readdatavalid = 1'b1;
      avl_readdata      = beat_data;
      beat_pend         = 1'b0;
    end
    if ((avl_read || avl_write) && wait_left > 0) begin
      avl_waitrequest_n = 1'b0;
      wait_left--;
    end else begin
      avl_waitrequest_n = 1'b1;
      if (avl_read && rd_delay > 0) begin
        beat_pend = 1'b1;
        beat_at   = cyc + rd_delay;
        beat_data = rd_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int id);
    for (int i = 0; i < 200; i++) begin
      if ((id == 0 && mem_ready) || (id == 1 && t_mem_ready)) begin
        if (id == 0) mem_valid = 1'b0;
        else         t_mem_valid = 1'b0;
        checks++;
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL ready_bound dut%0d no mem_ready within 200 cycles", id);
    mem_valid   = 1'b0;
    t_mem_valid = 1'b0;
  endtask

  task automatic issue0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int c0);
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_valid = 1'b1;
    c0        = cyc;
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_avl_read", avl_read, 0);
    chk("rst_avl_write", avl_write, 0);
    chk("rst_begin", avl_beginbursttransfer, 0);
    chk("rst_avl_address", avl_address, 0);
    chk("rst_avl_writedata", avl_writedata, 0);
    chk("rst_avl_byteenable", avl_byteenable, 0);
    chk("rst_burstcount", avl_burstcount, 1);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_calfail", err_calfail, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset_reset = 1'b1;
    mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    avl_waitrequest_n = 1'b1; avl_readdatavalid = 1'b0; avl_readdata = '0;
    local_init_done = 1'b1; local_cal_fail = 1'b0;
    t_mem_valid = 1'b0; t_mem_addr = '0; t_mem_wdata = '0; t_mem_wstrb = '0;
    t_avl_waitrequest_n = 1'b1; t_avl_readdatavalid = 1'b0; t_avl_readdata = '0;
    t_local_init_done = 1'b1; t_local_cal_fail = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    reset_reset = 1'b0;
    tick();

    // Write, no waitrequest: command in c0+1, ready in c0+2
    wait_left = 0; rd_delay = 0;
    issue0(32'h0000_0010, 32'h1234_5678, 4'b0011, c0);
    cmd_q.push_back('{c0 + 1, c0 + 1, 1'b1, 21'd4, 4'b0011, 32'h1234_5678});
    exp_q.push_back('{c0 + 2, 1'b0, 32'h0});
    wait_ready(0);
    tick();

    // Read: 3 waitrequest cycles, beat 5 cycles after accept
    wait_left = 3; rd_delay = 5; rd_data = 32'hCAFE_F00D;
    issue0(32'h0000_1000, 32'h0, 4'b0000, c0);
    cmd_q.push_back('{c0 + 1, c0 + 4, 1'b0, 21'h400, 4'hF, 32'h0});
    exp_q.push_back('{c0 + 10, 1'b1, 32'hCAFE_F00D});
    wait_ready(0);
    tick();

    // Held off by init_done low for 20 cycles
    wait_left = 0; rd_delay = 0;
    local_init_done = 1'b0;
    issue0(32'h0000_0020, 32'hA5A5_5A5A, 4'b1100, c0);
    cmd_q.push_back('{c0 + 21, c0 + 21, 1'b1, 21'd8, 4'b1100, 32'hA5A5_5A5A});
    exp_q.push_back('{c0 + 22, 1'b0, 32'h0});
    repeat (20) tick();
    local_init_done = 1'b1;
    wait_ready(0);
    tick();

    // Calibration failure: one-cycle completion, no Avalon traffic
    local_cal_fail = 1'b1;
    issue0(32'h0000_0040, 32'h7777_7777, 4'hF, c0);
    exp_q.push_back('{c0 + 1, 1'b0, 32'h0});
    wait_ready(0);
    tick();
    issue0(32'h0000_0044, 32'h0, 4'h0, c0);
    exp_q.push_back('{c0 + 1, 1'b1, 32'hDEAD_BEEF});
    wait_ready(0);
    chk("err_calfail_set", err_calfail, 1);
    chk("err_timeout_clear", err_timeout, 0);
    local_cal_fail = 1'b0;
    tick();

    // dut1: read with no response times out after 8 cycles
    t_mem_addr = 32'h0000_0100; t_mem_wstrb = 4'h0; t_mem_valid = 1'b1;
    c0 = cyc;
    t_exp_q.push_back('{c0 + 9, 1'b1, 32'hDEAD_BEEF});
    wait_ready(1);
    chk("t_err_timeout_set", t_err_timeout, 1);
    tick();
    // Next read: late beat is discarded, second beat delivered
    t_mem_addr = 32'h0000_0104; t_mem_valid = 1'b1;
    c0 = cyc;
    t_exp_q.push_back('{c0 + 4, 1'b1, 32'h2222_2222});
    tick();
    chk("t_cmd_read", t_avl_read, 1);
    chk("t_cmd_addr", t_avl_address, 21'h41);
    tick();
    t_avl_readdatavalid = 1'b1; t_avl_readdata = 32'h1111_1111;
    tick();
    t_avl_readdata = 32'h2222_2222;
    tick();
    t_avl_readdatavalid = 1'b0;
    wait_ready(1);
    tick();

    // Reset while dut0 waits in RDWAIT
    wait_left = 0; rd_delay = 0;
    issue0(32'h0000_0200, 32'h0, 4'h0, c0);
    cmd_q.push_back('{c0 + 1, c0 + 1, 1'b0, 21'h80, 4'hF, 32'h0});
    repeat (3) tick();
    mem_valid = 1'b0;
    reset_reset = 1'b1;
    tick();
    check_reset_vals();
    reset_reset = 1'b0;
    tick();

    // Post-reset read completes normally
    rd_delay = 2; rd_data = 32'h5A5A_A5A5;
    issue0(32'h0000_0204, 32'h0, 4'h0, c0);
    cmd_q.push_back('{c0 + 1, c0 + 1, 1'b0, 21'h81, 4'hF, 32'h0});
    exp_q.push_back('{c0 + 4, 1'b1, 32'h5A5A_A5A5});
    wait_ready(0);
    repeat (5) tick();

    chk("exp_q_drained", exp_q.size(), 0);
    chk("t_exp_q_drained", t_exp_q.size(), 0);
    chk("cmd_q_drained", cmd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
